// File: rtl/vend_if.sv
// Key strobe and display/status bundle between the keypad front end,
// vend_ctrl and the display path. The controller uses the slave modport.
interface vend_if #(
    parameter int AMT_W = 11
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic [2:0]       state_o;
    logic [AMT_W-1:0] disp_value;
    logic [2:0]       product_o;
    logic [2:0]       qty_o;
    logic             dispense;
    logic [AMT_W-1:0] change_o;
    logic             refund;

    modport master (
        output key_valid, key_code,
        input  state_o, disp_value, product_o, qty_o, dispense, change_o, refund
    );

    modport slave (
        input  key_valid, key_code,
        output state_o, disp_value, product_o, qty_o, dispense, change_o, refund
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending-machine controller: product select, quantity, confirm, coin
// payment, dispense, change and refund. All outputs are registered.
// Optional inactivity timeout is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
    parameter int                        N_PROD      = 5,
    parameter int                        PRICE_W     = 8,
    parameter logic [N_PROD*PRICE_W-1:0] PRICES      = {8'd1, 8'd2, 8'd5, 8'd10, 8'd6},
    parameter int                        MAX_QTY     = 3,
    parameter int                        TIMEOUT_CYC = 50_000_000,
    parameter int                        AMT_W       = PRICE_W + 3
) (
    input  logic   clk,
    input  logic   reset,
    vend_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SELECT     = 3'd1,
        S_SHOW_PRICE = 3'd2,
        S_QTY        = 3'd3,
        S_CONFIRM    = 3'd4,
        S_PAY        = 3'd5,
        S_DISPENSE   = 3'd6
    } state_t;

    localparam logic [3:0] KEY_COIN1  = 4'h8;
    localparam logic [3:0] KEY_COIN5  = 4'h9;
    localparam logic [3:0] KEY_COIN10 = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hC;
    localparam logic [3:0] KEY_TAKEN  = 4'hD;
    localparam logic [3:0] KEY_CONF   = 4'hE;
    localparam logic [3:0] KEY_OK     = 4'hF;

    // Unit price of a product, zero when no valid product is selected.
    function automatic logic [AMT_W-1:0] price_of(input logic [2:0] prod);
        logic [AMT_W-1:0] p;
        p = '0;
        for (int k = 1; k <= N_PROD; k++) begin
            if (prod == 3'(k)) begin
                p = AMT_W'(PRICES[k*PRICE_W-1 -: PRICE_W]);
            end
        end
        return p;
    endfunction

    state_t           state_q,    state_d;
    logic [2:0]       product_q,  product_d;
    logic [2:0]       qty_q,      qty_d;
    logic [AMT_W-1:0] total_q,    total_d;
    logic [AMT_W-1:0] paid_q,     paid_d;
    logic [AMT_W-1:0] change_q,   change_d;
    logic [AMT_W-1:0] disp_q,     disp_d;
    logic             dispense_q, dispense_d;
    logic             refund_q,   refund_d;

    logic             key_v_s;
    logic [3:0]       key_s;
    logic [AMT_W-1:0] coin_s;
    logic             is_coin_s;
    logic [AMT_W:0]   sum_wide_s;
    logic [AMT_W-1:0] sum_s;
    logic             timeout_s;

    assign key_v_s = bus.key_valid;
    assign key_s   = bus.key_code;

    // Coin value of the current key and the saturating new paid amount.
    always_comb begin
        coin_s    = '0;
        is_coin_s = 1'b0;
        case (key_s)
            KEY_COIN1:  begin coin_s = AMT_W'(1);  is_coin_s = 1'b1; end
            KEY_COIN5:  begin coin_s = AMT_W'(5);  is_coin_s = 1'b1; end
            KEY_COIN10: begin coin_s = AMT_W'(10); is_coin_s = 1'b1; end
            default:    begin coin_s = '0;         is_coin_s = 1'b0; end
        endcase
        sum_wide_s = {1'b0, paid_q} + {1'b0, coin_s};
        if (sum_wide_s[AMT_W]) begin
            sum_s = '1;
        end else begin
            sum_s = sum_wide_s[AMT_W-1:0];
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Timeout fires only on a keyless cycle once the count has reached the limit.
    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYC)) && !key_v_s;

    // Inactivity counter: restarts on any key or state change, holds at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (key_v_s || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Inactivity counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and datapath updates; leaving to IDLE clears the transaction.
    always_comb begin
        state_d    = state_q;
        product_d  = product_q;
        qty_d      = qty_q;
        total_d    = total_q;
        paid_d     = paid_q;
        change_d   = change_q;
        dispense_d = 1'b0;
        refund_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                product_d = '0;
                qty_d     = '0;
                total_d   = '0;
                paid_d    = '0;
                if (key_v_s && key_s == KEY_OK) begin
                    state_d  = S_SELECT;
                    change_d = '0;
                end
            end
            S_SELECT: begin
                if (key_v_s && key_s != 4'd0 && key_s <= 4'(N_PROD)) begin
                    product_d = key_s[2:0];
                    state_d   = S_SHOW_PRICE;
                end else if (key_v_s && key_s == KEY_CANCEL) begin
                    state_d = S_IDLE;
                end
            end
            S_SHOW_PRICE: begin
                if (key_v_s && key_s == KEY_OK) begin
                    qty_d   = 3'd1;
                    state_d = S_QTY;
                end else if (key_v_s && key_s == KEY_CANCEL) begin
                    state_d = S_IDLE;
                end
            end
            S_QTY: begin
                if (key_v_s && key_s != 4'd0 && key_s <= 4'(MAX_QTY)) begin
                    qty_d = key_s[2:0];
                end else if (key_v_s && key_s == KEY_OK) begin
                    total_d = price_of(product_q) * AMT_W'(qty_q);
                    state_d = S_CONFIRM;
                end else if (key_v_s && key_s == KEY_CANCEL) begin
                    state_d = S_IDLE;
                end
            end
            S_CONFIRM: begin
                if (key_v_s && key_s == KEY_CONF) begin
                    paid_d  = '0;
                    state_d = S_PAY;
                end else if (key_v_s && key_s == KEY_CANCEL) begin
                    state_d = S_IDLE;
                end
            end
            S_PAY: begin
                if (key_v_s && is_coin_s) begin
                    paid_d = sum_s;
                    if (sum_s >= total_q) begin
                        change_d   = sum_s - total_q;
                        dispense_d = 1'b1;
                        state_d    = S_DISPENSE;
                    end
                end else if (key_v_s && key_s == KEY_CANCEL) begin
                    change_d = paid_q;
                    refund_d = (paid_q != '0);
                    state_d  = S_IDLE;
                end
            end
            S_DISPENSE: begin
                if (key_v_s && key_s == KEY_TAKEN) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inactivity abort; coins already inserted are returned.
        if (timeout_s && state_q != S_IDLE && state_q != S_DISPENSE) begin
            state_d = S_IDLE;
            if (state_q == S_PAY) begin
                change_d = paid_q;
                refund_d = (paid_q != '0);
            end else begin
                refund_d = 1'b0;
            end
        end

        if (state_d == S_IDLE) begin
            product_d = '0;
            qty_d     = '0;
            total_d   = '0;
            paid_d    = '0;
        end
    end

    // Display value chosen from the state being entered so it is registered.
    always_comb begin
        disp_d = '0;
        case (state_d)
            S_SHOW_PRICE: disp_d = price_of(product_d);
            S_QTY:        disp_d = AMT_W'(qty_d);
            S_CONFIRM:    disp_d = total_d;
            S_PAY:        disp_d = paid_d;
            S_DISPENSE:   disp_d = change_d;
            default:      disp_d = '0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            product_q  <= '0;
            qty_q      <= '0;
            total_q    <= '0;
            paid_q     <= '0;
            change_q   <= '0;
            disp_q     <= '0;
            dispense_q <= 1'b0;
            refund_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            product_q  <= product_d;
            qty_q      <= qty_d;
            total_q    <= total_d;
            paid_q     <= paid_d;
            change_q   <= change_d;
            disp_q     <= disp_d;
            dispense_q <= dispense_d;
            refund_q   <= refund_d;
        end
    end

    assign bus.state_o    = state_q;
    assign bus.disp_value = disp_q;
    assign bus.product_o  = product_q;
    assign bus.qty_o      = qty_q;
    assign bus.dispense   = dispense_q;
    assign bus.change_o   = change_q;
    assign bus.refund     = refund_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: a transaction-level model checked on
// every falling edge, plus directed literal expectations.
module tb_vend_ctrl;
    localparam int AMT_W = 11;
    localparam int AMT_MAX = (1 << AMT_W) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   cmp_en;

    vend_if #(.AMT_W(AMT_W)) bus ();

    vend_ctrl #(.TIMEOUT_CYC(100)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model
    int price_tab [1:5] = '{6, 10, 5, 2, 1};
    int m_state, m_prod, m_qty, m_total, m_paid, m_change;
    bit m_disp_pulse, m_ref_pulse;

    task automatic model_clear();
        m_state = 0; m_prod = 0; m_qty = 0; m_total = 0; m_paid = 0;
    endtask

    task automatic model_key(input int k);
        int v;
        v = (k == 8) ? 1 : (k == 9) ? 5 : (k == 10) ? 10 : 0;
        if (m_state == 0) begin
            if (k == 15) begin m_state = 1; m_change = 0; end
        end else if (m_state == 6) begin
            if (k == 13) model_clear();
        end else if (k == 12) begin
            if (m_state == 5) begin
                m_change = m_paid;
                m_ref_pulse = (m_paid != 0);
            end
            model_clear();
        end else if (m_state == 1) begin
            if (k >= 1 && k <= 5) begin m_prod = k; m_state = 2; end
        end else if (m_state == 2) begin
            if (k == 15) begin m_qty = 1; m_state = 3; end
        end else if (m_state == 3) begin
            if (k >= 1 && k <= 3) m_qty = k;
            else if (k == 15) begin m_total = price_tab[m_prod] * m_qty; m_state = 4; end
        end else if (m_state == 4) begin
            if (k == 14) begin m_paid = 0; m_state = 5; end
        end else if (m_state == 5) begin
            if (v != 0) begin
                m_paid = (m_paid + v > AMT_MAX) ? AMT_MAX : m_paid + v;
                if (m_paid >= m_total) begin
                    m_change = m_paid - m_total;
                    m_disp_pulse = 1'b1;
                    m_state = 6;
                end
            end
        end
    endtask

    function automatic int model_disp();
        case (m_state)
            2: return price_tab[m_prod];
            3: return m_qty;
            4: return m_total;
            5: return m_paid;
            6: return m_change;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge (and asynchronously on reset)
    initial begin
        m_change = 0; m_disp_pulse = 0; m_ref_pulse = 0;
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
                m_change = 0; m_disp_pulse = 0; m_ref_pulse = 0;
            end else begin
                m_disp_pulse = 0;
                m_ref_pulse = 0;
                if (bus.key_valid) model_key(int'(bus.key_code));
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && rst_n) begin
                check("state",    int'(bus.state_o),    m_state);
                check("disp",     int'(bus.disp_value), model_disp());
                check("product",  int'(bus.product_o),  m_prod);
                check("qty",      int'(bus.qty_o),      m_qty);
                check("dispense", int'(bus.dispense),   int'(m_disp_pulse));
                check("change",   int'(bus.change_o),   m_change);
                check("refund",   int'(bus.refund),     int'(m_ref_pulse));
            end
        end
    end

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0; failures = 0; cmp_en = 1'b0;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        idle(2);
        check("rst_state",    int'(bus.state_o),    0);
        check("rst_disp",     int'(bus.disp_value), 0);
        check("rst_product",  int'(bus.product_o),  0);
        check("rst_qty",      int'(bus.qty_o),      0);
        check("rst_dispense", int'(bus.dispense),   0);
        check("rst_change",   int'(bus.change_o),   0);
        check("rst_refund",   int'(bus.refund),     0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // Happy path, exact payment (6 x 2 = 12)
        press(4'hF); check("hp_select", int'(bus.state_o), 1);
        press(4'h1); check("hp_price", int'(bus.disp_value), 6);
        press(4'hF);
        press(4'h2); check("hp_qty", int'(bus.qty_o), 2);
        press(4'hF); check("hp_total", int'(bus.disp_value), 12);
        check("hp_confirm", int'(bus.state_o), 4);
        press(4'hE);
        press(4'hA); check("hp_paid10", int'(bus.disp_value), 10);
        press(4'h8);
        press(4'h8);
        check("hp_disp_state", int'(bus.state_o), 6);
        check("hp_dispense", int'(bus.dispense), 1);
        check("hp_change", int'(bus.change_o), 0);
        idle(1);
        check("hp_dispense_once", int'(bus.dispense), 0);
        press(4'hD); check("hp_taken", int'(bus.state_o), 0);

        // Overpayment: product 3 (price 5), qty 1, coin 10
        press(4'hF); press(4'h3); press(4'hF); press(4'hF); press(4'hE);
        press(4'hA);
        check("op_state", int'(bus.state_o), 6);
        check("op_change", int'(bus.change_o), 5);
        press(4'hC); check("op_cancel_ignored", int'(bus.state_o), 6);
        press(4'hD); check("op_change_held", int'(bus.change_o), 5);
        idle(1);

        // Cancel mid-payment with illegal keys on the way: product 2, qty 3
        press(4'hF); check("cm_change_cleared", int'(bus.change_o), 0);
        press(4'h7); check("cm_key7_ignored", int'(bus.state_o), 1);
        press(4'h2); press(4'hF);
        press(4'h5); check("cm_qty5_ignored", int'(bus.qty_o), 1);
        press(4'h3); press(4'hF);
        check("cm_total", int'(bus.disp_value), 30);
        press(4'hE); press(4'h9); press(4'h9);
        check("cm_paid", int'(bus.disp_value), 10);
        press(4'hC);
        check("cm_refund", int'(bus.refund), 1);
        check("cm_change", int'(bus.change_o), 10);
        check("cm_state", int'(bus.state_o), 0);
        idle(1);
        check("cm_refund_once", int'(bus.refund), 0);

        // Async reset in PAY after a coin
        press(4'hF); press(4'h1); press(4'hF); press(4'hF); press(4'hE);
        press(4'h8);
        check("ar_pay", int'(bus.state_o), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_state",  int'(bus.state_o),    0);
        check("ar_disp",   int'(bus.disp_value), 0);
        check("ar_prod",   int'(bus.product_o),  0);
        check("ar_qty",    int'(bus.qty_o),      0);
        check("ar_change", int'(bus.change_o),   0);
        check("ar_refund", int'(bus.refund),     0);
        idle(1);
        rst_n = 1'b1;
        idle(2);

`ifdef VEND_TIMEOUT_EN
        // Timeout in PAY returns the inserted coin
        press(4'hF); press(4'h2); press(4'hF); press(4'hF); press(4'hE);
        press(4'h9);
        cmp_en = 1'b0;
        begin
            int n;
            bit seen;
            seen = 1'b0;
            n = 0;
            while (!seen && n < 200) begin
                idle(1);
                n++;
                if (bus.state_o == 3'd0) seen = 1'b1;
            end
            check("to_reached", int'(seen), 1);
            check("to_refund", int'(bus.refund), 1);
            check("to_change", int'(bus.change_o), 5);
            check("to_cycles_min", int'(n >= 99), 1);
        end
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
